// File: rtl/axis_out_packer.sv
// Serialises wide PE result words into BUS_WIDTH-bit AXI-Stream beats and marks frame ends with TLAST.
// Optional trailing XOR checksum beat per frame is enabled with `define OUT_PACKER_CHECKSUM_EN.
module axis_out_packer #(
    parameter int KERNEL_SIZE  = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int BUS_WIDTH    = 32,
    parameter int FRAME_ROWS   = 14,
    localparam int IN_WIDTH    = (DATA_WIDTH + WEIGHT_WIDTH + KERNEL_SIZE) * KERNEL_SIZE,
    localparam int BEATS       = (IN_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [BUS_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 frame_done,
    output logic [15:0]          frame_count
);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ROW_W  = (FRAME_ROWS > 1) ? $clog2(FRAME_ROWS) : 1;
    localparam int PAD_W  = BEATS * BUS_WIDTH;

    typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;

    state_t               state_reg;
    logic [PAD_W-1:0]     word_reg;
    logic [PAD_W-1:0]     in_pad;
    logic [BUS_WIDTH-1:0] slice [BEATS];
    logic [BEAT_W-1:0]    beat_reg;
    logic [BEAT_W-1:0]    beat_inc;
    logic [ROW_W-1:0]     row_reg;
    logic [ROW_W-1:0]     row_inc;
    logic [ROW_W-1:0]     load_row;
    logic [BUS_WIDTH-1:0] tdata_reg;
    logic                 tvalid_reg;
    logic                 tlast_reg;
    logic                 done_reg;
    logic [15:0]          count_reg;
`ifdef OUT_PACKER_CHECKSUM_EN
    logic [BUS_WIDTH-1:0] csum_reg;
`endif

    logic hs, accept, last_beat, last_row, csum_pending, first_last, next_beat_last;

    // Zero-extend the input so the final beat carries zeros above IN_WIDTH.
    always_comb begin
        in_pad                 = '0;
        in_pad[IN_WIDTH-1:0]   = s_axis_tdata;
    end

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
            assign slice[gi] = word_reg[gi*BUS_WIDTH +: BUS_WIDTH];
        end
    endgenerate

    assign hs        = tvalid_reg && m_axis_tready;
    assign last_beat = (beat_reg == BEAT_W'(BEATS - 1));
    assign last_row  = (row_reg == ROW_W'(FRAME_ROWS - 1));
    assign beat_inc  = beat_reg + 1'b1;
    assign row_inc   = last_row ? '0 : row_reg + 1'b1;
    // A word loaded in SEND belongs to the row after the one finishing now.
    assign load_row  = (state_reg == IDLE) ? row_reg : row_inc;

`ifdef OUT_PACKER_CHECKSUM_EN
    assign csum_pending   = (state_reg == CSUM) || last_row;
    assign first_last     = 1'b0;
    assign next_beat_last = 1'b0;
`else
    assign csum_pending   = 1'b0;
    assign first_last     = (BEATS == 1) && (load_row == ROW_W'(FRAME_ROWS - 1));
    assign next_beat_last = last_row && (beat_reg == BEAT_W'(BEATS - 2));
`endif

    assign s_axis_tready = (state_reg == IDLE) || (hs && last_beat && !csum_pending);
    assign accept        = s_axis_tvalid && s_axis_tready;

    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tlast  = tlast_reg;
    assign frame_done    = done_reg;
    assign frame_count   = count_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= IDLE;
            word_reg   <= '0;
            beat_reg   <= '0;
            row_reg    <= '0;
            tdata_reg  <= '0;
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
            done_reg   <= 1'b0;
            count_reg  <= '0;
`ifdef OUT_PACKER_CHECKSUM_EN
            csum_reg   <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        word_reg   <= in_pad;
                        tdata_reg  <= in_pad[BUS_WIDTH-1:0];
                        beat_reg   <= '0;
                        tvalid_reg <= 1'b1;
                        tlast_reg  <= first_last;
                        state_reg  <= SEND;
                    end
                end
                SEND: begin
                    if (hs) begin
`ifdef OUT_PACKER_CHECKSUM_EN
                        csum_reg <= csum_reg ^ tdata_reg;
`endif
                        if (!last_beat) begin
                            beat_reg  <= beat_inc;
                            tdata_reg <= slice[beat_inc];
                            tlast_reg <= next_beat_last;
                        end else begin
                            row_reg <= row_inc;
`ifdef OUT_PACKER_CHECKSUM_EN
                            if (last_row) begin
                                state_reg <= CSUM;
                                tdata_reg <= csum_reg ^ tdata_reg;
                                tlast_reg <= 1'b1;
                            end else
`endif
                            begin
                                if (tlast_reg) begin
                                    done_reg  <= 1'b1;
                                    count_reg <= count_reg + 1'b1;
                                end
                                if (accept) begin
                                    word_reg  <= in_pad;
                                    tdata_reg <= in_pad[BUS_WIDTH-1:0];
                                    beat_reg  <= '0;
                                    tlast_reg <= first_last;
                                end else begin
                                    tvalid_reg <= 1'b0;
                                    tlast_reg  <= 1'b0;
                                    state_reg  <= IDLE;
                                end
                            end
                        end
                    end
                end
`ifdef OUT_PACKER_CHECKSUM_EN
                CSUM: begin
                    if (hs) begin
                        csum_reg   <= '0;
                        done_reg   <= 1'b1;
                        count_reg  <= count_reg + 1'b1;
                        tvalid_reg <= 1'b0;
                        tlast_reg  <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
